// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;
`endif

    state_t               r_state;
    logic                 r_sync0;
    logic                 r_rx_s;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
    logic                 r_wait_high;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
    logic                 w_par_bad;

    assign w_par_bad  = (^r_shift) ^ r_par;
    assign parity_err = r_perr;
`endif

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync0 <= rx_in;
            r_rx_s  <= r_sync0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
            r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
            r_perr      <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    // After a low stop bit, stay disarmed until the line returns high.
                    if (r_wait_high) begin
                        if (r_rx_s) r_wait_high <= 1'b0;
                    end else if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_s) begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == CNT_MAX) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_clk_cnt == CNT_MAX) begin
                        r_clk_cnt <= '0;
                        r_par     <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_clk_cnt == CNT_MAX) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_CLEANUP;
                        r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_perr    <= w_par_bad;
                        if (r_rx_s && !w_par_bad) begin
`else
                        if (r_rx_s) begin
`endif
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else if (!r_rx_s) begin
                            r_ferr      <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receiving end of the 8N1 serial link driven by uart_tx.
- Samples the asynchronous serial line on the system clock and recovers each byte using mid-bit sampling.
- Presents each byte as a parallel word with a one-cycle valid strobe.
- Flags framing errors; sits between the board RX pin and the consuming logic (e.g. a character buffer or loopback checker).

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit period (100 MHz / 115200); minimum legal value 4.
- DATA_BITS, 8, payload bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_in  input  1  serial line, idle high, asynchronous to clk
- data_out  output  DATA_BITS  last received byte; held until the next valid frame completes
- data_valid  output  1  one-clk pulse when data_out is updated
- frame_err  output  1  one-clk pulse when the stop bit is sampled low
- busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset (async assert, sync release):
  - all outputs are 0 (data_out = 0, data_valid = 0, frame_err = 0, busy = 0).
  - Synchronizer flops reset to 1; FSM goes to IDLE; counters go to 0.
- Input sync: rx_in passes through 2 flops; only rx_s (the second flop) is used. This adds 2 clk of fixed latency.
- Counters:
  - clk_cnt spans 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT).
  - bit_idx spans 0..DATA_BITS-1.
- States:
  - IDLE: busy = 0. On rx_s = 0, go to START, clear clk_cnt, set busy = 1.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division).
    - rx_s still 0 at that point: clear clk_cnt, bit_idx = 0, go to DATA.
    - rx_s = 1 (glitch): return to IDLE. No strobe, no error.
  - DATA: each time clk_cnt reaches CLKS_PER_BIT-1, sample rx_s into the shift register at position bit_idx (LSB first), then clear clk_cnt.
    - After sampling bit DATA_BITS-1, go to STOP (or PARITY if enabled).
  - STOP: at clk_cnt = CLKS_PER_BIT-1, sample rx_s.
    - rx_s = 1: load data_out and pulse data_valid for exactly 1 clk.
    - rx_s = 0: pulse frame_err for 1 clk; data_out is unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: 1 clk, busy = 0, then IDLE.
    - If the stop bit was low, IDLE waits for rx_s = 1 before re-arming. A line held low (break) therefore produces exactly one frame_err, not a stream.
- Sampling point: every bit is sampled at its centre ±1 clk.
- Latency: data_valid asserts 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT clk (±1) after the falling edge of rx_in at the start bit.
- Back-to-back frames: a start bit immediately following the stop bit is detected without loss, because CLEANUP is 1 clk and the stop sample is at mid-bit.
- data_valid and frame_err are never high in the same cycle.
- Reset mid-frame: the frame is discarded with no strobe. After release, the receiver waits for the next falling edge in IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at bit centre.
  - Adds output parity_err (1 bit), which pulses for 1 clk in the STOP-sample cycle when the XOR of the data bits and the parity bit is 1.
  - data_valid is suppressed on a parity error; data_out is not updated.
  - Frame length becomes 11 bits.
- When undefined: no PARITY state, no parity_err port, 10-bit 8N1 frame exactly as above.

Test Plan (bench uses CLKS_PER_BIT = 16):
- Single byte: drive 0x54 ('T') as 8N1 at 16 clk/bit -> one data_valid pulse, data_out = 0x54, frame_err = 0, busy low after CLEANUP.
- Back-to-back: send "Tartz" (0x54, 0x61, 0x72, 0x74, 0x7A) with no idle gap -> 5 data_valid pulses, values in order, spacing exactly 160 clk.
- Framing error: send 0xA5 with the stop bit driven 0, then hold the line low for 40 clk -> exactly one frame_err pulse, no data_valid, data_out keeps its previous value; the next good 0x3C is received correctly.
- Glitch rejection: pulse rx_in low for 4 clk, then high -> returns to IDLE, no strobes, busy high for ≤ 10 clk.
- Reset mid-frame: assert rst_n low during data bit 3 of 0xFF -> all outputs 0 immediately; after release, the next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> data_valid, data_out = 0x07; send 0x07 with parity bit 0 -> parity_err pulse, no data_valid.
